// File: rtl/cmp_sort_ctrl.sv
// rtl/cmp_sort_ctrl.sv - block bubble sorter sharing one magnitude comparator (SORT_DESC_EN selects descending order)
module cmp_sort_ctrl #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         sort_done
);
    localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_POS = IW'(DEPTH - 2);

    typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [IW-1:0] pass_q, pass_d;
    logic [IW-1:0] pos_q, pos_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];

    logic [W-1:0]  cmp_a, cmp_b;
    logic          do_swap;

    always_comb begin
        cmp_a = mem_q[pos_q];
        cmp_b = mem_q[pos_q + IW'(1)];
`ifdef SORT_DESC_EN
        do_swap = cmp_a < cmp_b;
`else
        do_swap = cmp_a > cmp_b;
`endif
    end

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        pass_d    = pass_q;
        pos_d     = pos_q;
        mem_d     = mem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        sort_done = 1'b0;

        case (state_q)
            ST_LOAD: begin
                in_ready = !rst;
                if (in_valid) begin
                    mem_d[wr_idx_q] = in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = ST_SORT;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
            end
            ST_SORT: begin
                busy = !rst;
                // Fixed schedule: every pass walks all adjacent pairs, no early exit.
                if (do_swap) begin
                    mem_d[pos_q]          = cmp_b;
                    mem_d[pos_q + IW'(1)] = cmp_a;
                end
                if (pos_q == LAST_POS) begin
                    pos_d = '0;
                    if (pass_q == LAST_POS) begin
                        sort_done = !rst;
                        pass_d    = '0;
                        rd_idx_d  = '0;
                        state_d   = ST_DRAIN;
                    end else begin
                        pass_d = pass_q + IW'(1);
                    end
                end else begin
                    pos_d = pos_q + IW'(1);
                end
            end
            ST_DRAIN: begin
                out_valid = !rst;
                out_data  = rst ? '0 : mem_q[rd_idx_q];
                if (out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = ST_LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            pass_q   <= '0;
            pos_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            pass_q   <= pass_d;
            pos_q    <= pos_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb/tb_cmp_sort_ctrl.sv - scoreboard bench for cmp_sort_ctrl (W=3, DEPTH=4)
module tb_cmp_sort_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       sort_done;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb_q[$];
    int pat[7];
    int plen;

    cmp_sort_ctrl #(.W(3), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .sort_done (sort_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks hold stability under stall.
    logic       stall_prev = 1'b0;
    logic [2:0] held_data;
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (stall_prev) chk("hold_data", out_data, held_data);
            if (out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("out_data", out_data, sb_q.pop_front());
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                held_data  = out_data;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic load4(input logic [2:0] w0, w1, w2, w3);
        logic [2:0] w[4];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            @(negedge clk);
            chk("load_in_ready", in_ready, 1);
            step();
        end
        in_data = 3'd6;
    endtask

    task automatic run_block(input logic [2:0] w0, w1, w2, w3,
                             input logic [2:0] e0, e1, e2, e3,
                             input int exp_drain_cycles);
        int busy_cnt, done_cnt, done_at, xfers, k, guard;
        sb_q.push_back(e0);
        sb_q.push_back(e1);
        sb_q.push_back(e2);
        sb_q.push_back(e3);
        out_ready = pat[0] != 0;
        load4(w0, w1, w2, w3);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (out_valid) break;
            if (busy) busy_cnt++;
            if (sort_done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (in_ready) chk("sort_in_ready", in_ready, 0);
            step();
        end
        chk("busy_cycles", busy_cnt, 9);
        chk("sort_done_count", done_cnt, 1);
        chk("sort_done_last", done_at, 9);
        xfers = 0;
        k     = 0;
        guard = 0;
        while (xfers < 4 && guard < 40) begin
            if (in_ready) chk("drain_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                xfers++;
                if (xfers == 4) in_valid = 1'b0;
            end
            step();
            k++;
            guard++;
            out_ready = pat[k % plen] != 0;
            @(negedge clk);
        end
        chk("drain_cycles", k, exp_drain_cycles);
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pat  = '{1, 1, 1, 1, 1, 1, 1};
        plen = 1;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 3'd6;
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_sort_done", sort_done, 0);
            chk("rst_out_data", out_data, 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_busy", busy, 0);
        step();

`ifdef SORT_DESC_EN
        run_block(3'd5, 3'd2, 3'd7, 3'd1, 3'd7, 3'd5, 3'd2, 3'd1, 4);
        run_block(3'd3, 3'd3, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 4);
        run_block(3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 4);
        run_block(3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 4);
        pat  = '{1, 0, 0, 1, 1, 0, 1};
        plen = 7;
        run_block(3'd2, 3'd6, 3'd1, 3'd4, 3'd6, 3'd4, 3'd2, 3'd1, 7);
`else
        run_block(3'd5, 3'd2, 3'd7, 3'd1, 3'd1, 3'd2, 3'd5, 3'd7, 4);
        run_block(3'd3, 3'd3, 3'd0, 3'd3, 3'd0, 3'd3, 3'd3, 3'd3, 4);
        run_block(3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 4);
        run_block(3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 4);
        pat  = '{1, 0, 0, 1, 1, 0, 1};
        plen = 7;
        run_block(3'd2, 3'd6, 3'd1, 3'd4, 3'd1, 3'd2, 3'd4, 3'd6, 7);
`endif
        pat  = '{1, 1, 1, 1, 1, 1, 1};
        plen = 1;
        out_ready = 1'b1;

        // Abort mid-SORT: rst sampled at the end of the 4th SORT cycle.
        load4(3'd5, 3'd2, 3'd7, 3'd1);
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("midsort_rst_busy", busy, 0);
        chk("midsort_rst_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midsort_rel_in_ready", in_ready, 1);
        chk("midsort_rel_busy", busy, 0);
        chk("midsort_rel_out_valid", out_valid, 0);
        step();
`ifdef SORT_DESC_EN
        run_block(3'd6, 3'd4, 3'd4, 3'd1, 3'd6, 3'd4, 3'd4, 3'd1, 4);
`else
        run_block(3'd6, 3'd4, 3'd4, 3'd1, 3'd1, 3'd4, 3'd4, 3'd6, 4);
`endif
        step();
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
- Sequencing controller that shares one unsigned magnitude comparator (gt/lt/eq style) to sort a small block of W-bit words.
- Accepts DEPTH words over a valid/ready input, runs a fixed-schedule bubble sort with one compare-and-swap per cycle, then streams the sorted words out over a valid/ready output.
- Sits downstream of the combinational comparator blocks as their first sequenced user.

Parameters:
- W, 3, data word width in bits (>=1).
- DEPTH, 4, words per sort block (>=2).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word on in_data.
- in_data  in  W  unsigned input word.
- in_ready  out  1  block accepts a word this cycle.
- out_valid  out  1  out_data holds a sorted word.
- out_data  out  W  sorted output word.
- out_ready  in  1  consumer accepts out_data this cycle.
- busy  out  1  high while in SORT.
- sort_done  out  1  one-cycle pulse on the last SORT cycle.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset, sampled at clk edge:
  - state=LOAD; all indices 0; storage cleared to 0.
  - While rst is high: in_ready=0, out_valid=0, busy=0, sort_done=0, out_data=0.
  - First cycle after rst deasserts: in_ready=1.
- Storage: DEPTH x W registers mem[0..DEPTH-1]; index width $clog2(DEPTH).
- LOAD:
  - in_ready=1, out_valid=0, busy=0.
  - Transfer on in_valid&&in_ready writes mem[wr_idx] and increments wr_idx.
  - The transfer with wr_idx==DEPTH-1 goes to SORT next cycle, with wr_idx=0.
- SORT:
  - in_ready=0, busy=1; in_valid is ignored.
  - Pass counter p in 0..DEPTH-2; position j in 0..DEPTH-2.
  - Each cycle compares mem[j] vs mem[j+1], unsigned. If mem[j] > mem[j+1], swap both in the same cycle; equal values never swap (stable).
  - j increments every cycle. When j==DEPTH-2, j wraps to 0 and p increments.
  - Fixed schedule, no early exit: SORT lasts exactly (DEPTH-1)*(DEPTH-1) cycles (9 for DEPTH=4), independent of data.
  - sort_done=1 on the cycle with p==DEPTH-2 and j==DEPTH-2. Next state is DRAIN with rd_idx=0.
- DRAIN:
  - out_valid=1, out_data=mem[rd_idx], in_ready=0.
  - Transfer on out_valid&&out_ready increments rd_idx.
  - While out_ready=0, out_data and out_valid are held stable.
  - Transfer at rd_idx==DEPTH-1 returns to LOAD next cycle. The block accepts new input no earlier than the cycle after the last output transfer (no overlap).
- Latency: first out_valid occurs DEPTH + (DEPTH-1)^2 cycles after the first input transfer, with continuous in_valid.
- Outputs in_ready, out_valid, busy and out_data are decoded from registered state only. There are no combinational paths from in_valid or out_ready to any output.
- Reset asserted mid-LOAD, mid-SORT or mid-DRAIN aborts the block: partial data is discarded and reset values apply.

Optional Feature:
- Macro SORT_DESC_EN.
- Defined: swap condition becomes mem[j] < mem[j+1], so output is descending; equal values still never swap.
- Undefined: ascending order as above.
- Timing, ports and handshake are identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, busy=0; in_ready=1 on the first cycle after release; no word captured during reset.
- Basic sort: load 5,2,7,1 back-to-back -> busy high exactly 9 cycles starting the cycle after the 4th accept; sort_done pulses once on its last cycle; with out_ready=1, drain 1,2,5,7 on 4 consecutive cycles; in_ready=1 the cycle after.
- Duplicates/presorted: 3,3,0,3 -> 0,3,3,3; 0,1,2,3 -> 0,1,2,3 with the same 9-cycle busy window; 7,7,7,7 -> 7,7,7,7.
- Backpressure: during DRAIN drive out_ready pattern 1,0,0,1,1,0,1 -> each word held stable while stalled; exactly 4 transfers, in order; in_valid=1 throughout SORT/DRAIN is never accepted (in_ready=0).
- Reset mid-SORT: after loading 5,2,7,1 assert rst on the 4th SORT cycle -> LOAD, busy=0; then load 6,4,4,1 -> 1,4,4,6.
- SORT_DESC_EN build: load 5,2,7,1 -> 7,5,2,1; load 3,3,0,3 -> 3,3,3,0; busy window still 9 cycles.
